// File: rtl/ahbl_pkg.sv
// ---------------------------------------------------------------------------
// ahbl_pkg
// Shared AHB-Lite definitions for the exclusive-access monitor slice.
//   - HTRANS encodings
//   - granule_of():   address -> reservation granule (address >> granule_log2)
//   - master_known(): true when an hmaster value maps onto a reservation entry
// ---------------------------------------------------------------------------
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int unsigned W_HMASTER = 8;

  // Callers zero-extend their address to 64 bits and truncate the result to
  // their own tag width, which keeps this helper independent of W_ADDR.
  function automatic logic [63:0] granule_of(input logic [63:0] addr,
                                             input int unsigned granule_log2);
    return addr >> granule_log2;
  endfunction

  function automatic logic master_known(input logic [W_HMASTER-1:0] hmaster,
                                        input int unsigned n_masters);
    return (32'(hmaster) < n_masters);
  endfunction

endpackage

// File: rtl/ahbl_excl_resv_table.sv
// ---------------------------------------------------------------------------
// ahbl_excl_resv_table
// One reservation (valid + granule tag) per master.
// Ports:
//   clk, rst             clock, synchronous active-high reset (clears valids)
//   set_en/idx/tag       write entry[idx] = {1, tag}
//   clr_en/clr_tag       invalidate every entry whose tag equals clr_tag
//   clr_idx_en/clr_idx   invalidate entry[clr_idx]
//   lookup_idx/tag/hit   combinational lookup against the table *as it will
//                        be after this cycle's set/clear* (forwarded view)
// ---------------------------------------------------------------------------
module ahbl_excl_resv_table #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned W_TAG     = 29,
  parameter int unsigned W_IDX     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [W_IDX-1:0] set_idx,
  input  logic [W_TAG-1:0] set_tag,
  input  logic             clr_en,
  input  logic [W_TAG-1:0] clr_tag,
  input  logic             clr_idx_en,
  input  logic [W_IDX-1:0] clr_idx,
  input  logic [W_IDX-1:0] lookup_idx,
  input  logic [W_TAG-1:0] lookup_tag,
  output logic             lookup_hit
);

  // Hit vector padded to the full index range so any lookup_idx is in range.
  localparam int unsigned N_SLOTS = 2 ** W_IDX;

  logic [N_SLOTS-1:0] hit_vec;

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_entry
      if (gi < N_MASTERS) begin : g_real
        logic             valid_reg, valid_next;
        logic [W_TAG-1:0] tag_reg, tag_next;

        // A set and a clear never coincide (they come from one data phase),
        // so the ordering below only matters for robustness.
        always_comb begin
          valid_next = valid_reg;
          tag_next   = tag_reg;
          if (clr_en && (tag_reg == clr_tag)) begin
            valid_next = 1'b0;
          end
          if (clr_idx_en && (clr_idx == W_IDX'(gi))) begin
            valid_next = 1'b0;
          end
          if (set_en && (set_idx == W_IDX'(gi))) begin
            valid_next = 1'b1;
            tag_next   = set_tag;
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
          end else begin
            valid_reg <= valid_next;
            tag_reg   <= tag_next;
          end
        end

        // Lookup uses the next-state view so a check issued in the same cycle
        // as a completing update already sees that update.
        assign hit_vec[gi] = valid_next && (tag_next == lookup_tag);
      end else begin : g_pad
        assign hit_vec[gi] = 1'b0;
      end
    end
  endgenerate

  assign lookup_hit = hit_vec[lookup_idx];

endmodule

// File: rtl/ahbl_excl_monitor.sv
// ---------------------------------------------------------------------------
// ahbl_excl_monitor
// Global exclusive-access monitor between a crossbar slave port (src_*) and a
// shared AHB-Lite memory slave (dst_*). Zero wait states added; all transfer
// signals pass through combinationally.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   src_hready               bus HREADY from the crossbar
//   src_haddr..src_hwdata    address/data-phase signals from the crossbar
//   src_hexcl, src_hmaster   exclusive flag and master id (address phase)
//   src_hready_resp, src_hresp, src_hrdata, src_hexokay   response to crossbar
//   dst_*                    pass-through to the slave; dst_htrans is forced
//                            IDLE for a failing exclusive write
// A failing exclusive write never reaches the slave: the monitor owns its
// single-cycle OKAY data phase with hrdata=0 and hexokay=0.
// ---------------------------------------------------------------------------
module ahbl_excl_monitor
  import ahbl_pkg::*;
#(
  parameter int unsigned N_MASTERS    = 2,
  parameter int unsigned W_ADDR       = 32,
  parameter int unsigned W_DATA       = 32,
  parameter int unsigned GRANULE_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_hready,
  output logic              src_hready_resp,
  output logic              src_hresp,
  input  logic [W_ADDR-1:0] src_haddr,
  input  logic              src_hwrite,
  input  logic [1:0]        src_htrans,
  input  logic [2:0]        src_hsize,
  input  logic [2:0]        src_hburst,
  input  logic [3:0]        src_hprot,
  input  logic              src_hmastlock,
  input  logic [W_DATA-1:0] src_hwdata,
  output logic [W_DATA-1:0] src_hrdata,
  input  logic              src_hexcl,
  input  logic [7:0]        src_hmaster,
  output logic              src_hexokay,
  output logic              dst_hready,
  input  logic              dst_hready_resp,
  input  logic              dst_hresp,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [2:0]        dst_hburst,
  output logic [3:0]        dst_hprot,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata,
  input  logic [W_DATA-1:0] dst_hrdata
);

  localparam int unsigned W_IDX = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned W_TAG = W_ADDR - GRANULE_LOG2;

  // ---------------- address phase decode ----------------
  logic             a_accept;
  logic             a_known;
  logic [W_IDX-1:0] a_midx;
  logic [W_TAG-1:0] a_granule;
  logic             a_hit;
  logic             a_pass;
  logic             a_supp;

  assign a_accept  = src_hready & src_htrans[1];
  assign a_known   = master_known(src_hmaster, N_MASTERS);
  assign a_midx    = src_hmaster[W_IDX-1:0];
  assign a_granule = W_TAG'(granule_of(64'(src_haddr), GRANULE_LOG2));
  assign a_pass    = a_known & a_hit;
  assign a_supp    = a_accept & src_hexcl & src_hwrite & ~a_pass;

  // ---------------- data-phase state ----------------
  logic             dp_valid_reg,   dp_valid_next;
  logic             dp_write_reg,   dp_write_next;
  logic             dp_excl_reg,    dp_excl_next;
  logic             dp_known_reg,   dp_known_next;
  logic [W_IDX-1:0] dp_midx_reg,    dp_midx_next;
  logic [W_TAG-1:0] dp_granule_reg, dp_granule_next;
  logic             dp_supp_reg,    dp_supp_next;

  always_comb begin
    dp_valid_next   = dp_valid_reg;
    dp_write_next   = dp_write_reg;
    dp_excl_next    = dp_excl_reg;
    dp_known_next   = dp_known_reg;
    dp_midx_next    = dp_midx_reg;
    dp_granule_next = dp_granule_reg;
    dp_supp_next    = dp_supp_reg;
    if (src_hready) begin
      dp_valid_next   = a_accept;
      dp_write_next   = src_hwrite;
      dp_excl_next    = src_hexcl;
      dp_known_next   = a_known;
      dp_midx_next    = a_midx;
      dp_granule_next = a_granule;
      dp_supp_next    = a_supp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid_reg   <= 1'b0;
      dp_write_reg   <= 1'b0;
      dp_excl_reg    <= 1'b0;
      dp_known_reg   <= 1'b0;
      dp_midx_reg    <= '0;
      dp_granule_reg <= '0;
      dp_supp_reg    <= 1'b0;
    end else begin
      dp_valid_reg   <= dp_valid_next;
      dp_write_reg   <= dp_write_next;
      dp_excl_reg    <= dp_excl_next;
      dp_known_reg   <= dp_known_next;
      dp_midx_reg    <= dp_midx_next;
      dp_granule_reg <= dp_granule_next;
      dp_supp_reg    <= dp_supp_next;
    end
  end

  // ---------------- response path ----------------
  // With no transfer in its data phase (including straight after reset) the
  // monitor answers OKAY/ready itself; a suppressed write is likewise owned
  // here because the slave only ever saw IDLE.
  always_comb begin
    src_hready_resp = 1'b1;
    src_hresp       = 1'b0;
    src_hrdata      = dst_hrdata;
    if (dp_valid_reg && !dp_supp_reg) begin
      src_hready_resp = dst_hready_resp;
      src_hresp       = dst_hresp;
    end
    if (dp_valid_reg && dp_supp_reg) begin
      src_hrdata = '0;
    end
  end

  // Successful completion of a transfer the slave actually performed.
  logic dp_ok;
  assign dp_ok = dp_valid_reg & ~dp_supp_reg & src_hready_resp & ~src_hresp;

  logic set_en, clr_en, clr_idx_en;
  assign set_en     = dp_ok & dp_excl_reg & ~dp_write_reg & dp_known_reg;
  assign clr_en     = dp_ok & dp_write_reg;
  assign clr_idx_en = dp_ok & dp_write_reg & dp_excl_reg & dp_known_reg;

  // A non-suppressed exclusive write has passed, which implies a known master.
  assign src_hexokay = dp_ok & dp_excl_reg & (dp_write_reg | dp_known_reg);

  ahbl_excl_resv_table #(
    .N_MASTERS (N_MASTERS),
    .W_TAG     (W_TAG),
    .W_IDX     (W_IDX)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .set_en     (set_en),
    .set_idx    (dp_midx_reg),
    .set_tag    (dp_granule_reg),
    .clr_en     (clr_en),
    .clr_tag    (dp_granule_reg),
    .clr_idx_en (clr_idx_en),
    .clr_idx    (dp_midx_reg),
    .lookup_idx (a_midx),
    .lookup_tag (a_granule),
    .lookup_hit (a_hit)
  );

  // ---------------- pass-through ----------------
  assign dst_hready    = src_hready;
  assign dst_haddr     = src_haddr;
  assign dst_hwrite    = src_hwrite;
  assign dst_htrans    = a_supp ? HTRANS_IDLE : src_htrans;
  assign dst_hsize     = src_hsize;
  assign dst_hburst    = src_hburst;
  assign dst_hprot     = src_hprot;
  assign dst_hmastlock = src_hmastlock;
  assign dst_hwdata    = src_hwdata;

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// ---------------------------------------------------------------------------
// tb_ahbl_excl_monitor
// Drives pipelined AHB-Lite transfers into the monitor, with a memory slave
// model behind it. Expected responses come from a reference model of the
// reservation rules and are queued at issue time; a monitor process pops and
// compares them as address and data phases complete.
// ---------------------------------------------------------------------------
module tb_ahbl_excl_monitor;
  import ahbl_pkg::*;

  localparam int N_MASTERS    = 2;
  localparam int W_ADDR       = 32;
  localparam int W_DATA       = 32;
  localparam int GRANULE_LOG2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              src_hready, src_hready_resp, src_hresp;
  logic [W_ADDR-1:0] src_haddr;
  logic              src_hwrite;
  logic [1:0]        src_htrans;
  logic [2:0]        src_hsize, src_hburst;
  logic [3:0]        src_hprot;
  logic              src_hmastlock;
  logic [W_DATA-1:0] src_hwdata, src_hrdata;
  logic              src_hexcl;
  logic [7:0]        src_hmaster;
  logic              src_hexokay;
  logic              dst_hready, dst_hready_resp, dst_hresp;
  logic [W_ADDR-1:0] dst_haddr;
  logic              dst_hwrite;
  logic [1:0]        dst_htrans;
  logic [2:0]        dst_hsize, dst_hburst;
  logic [3:0]        dst_hprot;
  logic              dst_hmastlock;
  logic [W_DATA-1:0] dst_hwdata, dst_hrdata;

  // Single-slave bus: HREADY is this port's own HREADYOUT.
  assign src_hready = src_hready_resp;

  ahbl_excl_monitor #(
    .N_MASTERS(N_MASTERS), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .GRANULE_LOG2(GRANULE_LOG2)
  ) dut (
    .clk(clk), .rst(rst),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
    .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
    .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
    .src_hexcl(src_hexcl), .src_hmaster(src_hmaster), .src_hexokay(src_hexokay),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
    .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
    .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata)
  );

  // ---------------- slave model (256-word memory, cleared by rst) ----------------
  int          cfg_wait;
  bit          cfg_err;
  logic        s_pend, s_write, s_err, s_err2;
  int          s_cnt;
  logic [31:0] s_addr, s_rdata;
  logic [31:0] smem [256];
  logic        s_done;

  assign s_done = s_pend && (s_cnt == 0) && (!s_err || s_err2);

  always_comb begin
    dst_hready_resp = 1'b1;
    dst_hresp       = 1'b0;
    dst_hrdata      = 32'hDEAD_BEEF;
    if (s_pend) begin
      if (s_cnt > 0) dst_hready_resp = 1'b0;
      else if (s_err) begin
        dst_hresp       = 1'b1;
        dst_hready_resp = s_err2;
      end else if (!s_write) dst_hrdata = s_rdata;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      s_pend <= 1'b0; s_cnt <= 0; s_err <= 1'b0; s_err2 <= 1'b0;
      s_write <= 1'b0; s_addr <= '0; s_rdata <= '0;
      for (int i = 0; i < 256; i++) smem[i] <= '0;
    end else begin
      if (s_pend) begin
        if (s_cnt > 0) s_cnt <= s_cnt - 1;
        else if (s_err && !s_err2) s_err2 <= 1'b1;
        else begin
          s_pend <= 1'b0;
          if (s_write && !s_err) smem[s_addr[9:2]] <= dst_hwdata;
        end
      end
      if (dst_hready && dst_htrans[1]) begin
        s_pend  <= 1'b1;
        s_write <= dst_hwrite;
        s_addr  <= dst_haddr;
        s_cnt   <= cfg_wait;
        s_err   <= cfg_err;
        s_err2  <= 1'b0;
        s_rdata <= (s_done && s_write && !s_err && (s_addr[9:2] == dst_haddr[9:2]))
                   ? dst_hwdata : smem[dst_haddr[9:2]];
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct { logic [31:0] addr; logic write; logic supp; } addr_exp_t;
  typedef struct { logic write; logic supp; logic hresp; logic hexokay; logic [31:0] rdata; } resp_exp_t;

  addr_exp_t   addr_q[$];
  resp_exp_t   resp_q[$];
  bit          ref_valid [N_MASTERS];
  int unsigned ref_gran  [N_MASTERS];
  logic [31:0] ref_mem   [256];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic model_clear();
    for (int i = 0; i < N_MASTERS; i++) begin ref_valid[i] = 0; ref_gran[i] = 0; end
    for (int w = 0; w < 256; w++) ref_mem[w] = '0;
  endtask

  // Transfers are applied to the model in issue order: the previous transfer's
  // table update always lands no later than the next transfer's check.
  task automatic issue(input int m, input logic [31:0] addr, input bit wr, input bit ex,
                       input int wt, input bit er);
    logic [31:0] wd;
    bit known, pass, supp;
    int unsigned g;
    int n;
    addr_exp_t ae;
    resp_exp_t re;
    wd    = $urandom;
    known = (m < N_MASTERS);
    g     = addr >> GRANULE_LOG2;
    pass  = 0;
    if (known) pass = ref_valid[m] && (ref_gran[m] == g);
    supp  = wr && ex && !pass;
    re.write = wr; re.supp = supp; re.hresp = 0; re.hexokay = 0; re.rdata = '0;
    if (!supp) begin
      if (er) re.hresp = 1;
      else if (wr) begin
        ref_mem[addr[9:2]] = wd;
        for (int i = 0; i < N_MASTERS; i++)
          if (ref_valid[i] && ref_gran[i] == g) ref_valid[i] = 0;
        if (ex) begin ref_valid[m] = 0; re.hexokay = 1; end
      end else begin
        re.rdata = ref_mem[addr[9:2]];
        if (ex && known) begin ref_valid[m] = 1; ref_gran[m] = g; re.hexokay = 1; end
      end
    end
    ae.addr = addr; ae.write = wr; ae.supp = supp;
    addr_q.push_back(ae);
    resp_q.push_back(re);

    src_haddr = addr; src_hwrite = wr; src_hexcl = ex; src_hmaster = 8'(m);
    src_htrans = HTRANS_NONSEQ; cfg_wait = wt; cfg_err = er;
    @(negedge clk);
    n = 0;
    while (!src_hready && n < 64) begin @(negedge clk); n++; end
    if (!src_hready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout addr=%h: hready stayed 0, required 1", addr);
    end
    @(posedge clk); #1;
    src_htrans = HTRANS_IDLE;
    src_hwdata = wr ? wd : 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    src_htrans = HTRANS_IDLE;
    addr_q.delete();
    resp_q.delete();
    model_clear();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check1("reset_hready_resp", src_hready_resp, 1'b1);
    check1("reset_hresp", src_hresp, 1'b0);
    check1("reset_hexokay", src_hexokay, 1'b0);
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit        dp_pend;
    resp_exp_t re;
    addr_exp_t ae;
    logic      rd_chk;
    dp_pend = 0;
    forever begin
      @(negedge clk);
      if (rst) dp_pend = 0;
      else begin
        if (dp_pend) begin
          if (src_hready_resp) begin
            vectors++;
            if (resp_q.size() == 0) begin
              miscompares++;
              $display("FAIL resp_unexpected: data phase completed with no expected transfer");
            end else begin
              re = resp_q.pop_front();
              rd_chk = re.supp || (!re.write && !re.hresp);
              if (src_hresp !== re.hresp || src_hexokay !== re.hexokay ||
                  (rd_chk && src_hrdata !== re.rdata)) begin
                miscompares++;
                $display("FAIL resp: got hresp=%b hexokay=%b hrdata=%h, required hresp=%b hexokay=%b hrdata=%h%s",
                         src_hresp, src_hexokay, src_hrdata, re.hresp, re.hexokay, re.rdata,
                         rd_chk ? "" : " (hrdata not checked)");
              end
            end
          end else begin
            vectors++;
            if (src_hexokay !== 1'b0) begin
              miscompares++;
              $display("FAIL hexokay_wait: got %b during a stalled data phase, required 0", src_hexokay);
            end
          end
        end
        if (src_hready) begin
          if (src_htrans[1]) begin
            vectors++;
            if (addr_q.size() == 0) begin
              miscompares++;
              $display("FAIL addr_unexpected: accepted address phase with no expected transfer");
            end else begin
              ae = addr_q.pop_front();
              if (dst_htrans !== (ae.supp ? HTRANS_IDLE : HTRANS_NONSEQ) ||
                  dst_haddr !== ae.addr || dst_hwrite !== ae.write) begin
                miscompares++;
                $display("FAIL addr: got dst_htrans=%b haddr=%h hwrite=%b, required dst_htrans=%b haddr=%h hwrite=%b",
                         dst_htrans, dst_haddr, dst_hwrite,
                         ae.supp ? HTRANS_IDLE : HTRANS_NONSEQ, ae.addr, ae.write);
              end
            end
            dp_pend = 1;
          end else dp_pend = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    src_haddr = '0; src_hwrite = 0; src_htrans = HTRANS_IDLE; src_hsize = 3'd2;
    src_hburst = 3'd0; src_hprot = 4'b0011; src_hmastlock = 0; src_hwdata = '0;
    src_hexcl = 0; src_hmaster = '0; cfg_wait = 0; cfg_err = 0;
    model_clear();
    do_reset(2);

    // exclusive read then passing exclusive write, read back
    issue(0, 32'h100, 0, 1, 0, 0);
    issue(0, 32'h100, 1, 1, 0, 0);
    issue(0, 32'h100, 0, 0, 0, 0);
    // another master's write to the same granule kills the reservation
    issue(0, 32'h100, 0, 1, 0, 0);
    issue(1, 32'h104, 1, 0, 0, 0);
    issue(0, 32'h100, 1, 1, 0, 0);
    issue(0, 32'h100, 0, 0, 1, 0);
    // both reserve; master 1 wins back-to-back, master 0 sees the forwarded clear
    issue(0, 32'h200, 0, 1, 0, 0);
    issue(1, 32'h200, 0, 1, 0, 0);
    issue(1, 32'h200, 1, 1, 0, 0);
    issue(0, 32'h200, 1, 1, 0, 0);
    idle(1);
    // unknown master
    issue(5, 32'h300, 1, 1, 0, 0);
    issue(5, 32'h300, 0, 1, 0, 0);
    issue(5, 32'h300, 1, 1, 0, 0);
    // exclusive read with error response sets nothing
    issue(1, 32'h180, 0, 1, 0, 1);
    issue(1, 32'h180, 1, 1, 0, 0);
    issue(1, 32'h180, 0, 0, 0, 0);
    idle(2);
    // reserve, then reset in the middle of a stalled exclusive read
    issue(0, 32'h340, 0, 1, 0, 0);
    issue(0, 32'h340, 0, 1, 3, 0);
    idle(1);
    do_reset(1);
    issue(0, 32'h340, 1, 1, 0, 0);
    issue(0, 32'h340, 0, 0, 0, 0);
    idle(2);

    // randomized traffic over a few contended granules
    for (int k = 0; k < 300; k++) begin
      int m, wt;
      bit wr, ex, er;
      logic [31:0] a;
      m  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 1));
      a  = 32'h280 + 32'(8 * $urandom_range(0, 3)) + 32'(4 * $urandom_range(0, 1));
      wr = bit'($urandom_range(0, 1));
      ex = ($urandom_range(0, 2) != 0);
      wt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      er = ($urandom_range(0, 11) == 0);
      issue(m, a, wr, ex, wt, er);
      if ($urandom_range(0, 4) == 0) idle(1);
    end

    n = 0;
    while ((resp_q.size() != 0 || addr_q.size() != 0) && n < 200) begin
      @(posedge clk); n++;
    end
    #1;
    vectors++;
    if (resp_q.size() != 0 || addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses and %0d addresses outstanding, required 0",
               resp_q.size(), addr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahbl_excl_monitor.md
Name: ahbl_excl_monitor

Overview:
Global exclusive-access monitor placed on one crossbar slave port, between the crossbar's downstream AHB-Lite master port and a shared memory slave (e.g. SRAM).
- Tracks one reservation per master, keyed by hmaster.
- Decides pass/fail for exclusive stores. Failed stores are suppressed before they reach the slave.
- Drives hexokay back to the crossbar.
- Adds zero wait states; all transfer signals pass through combinationally.

Parameters:
- N_MASTERS, 2, number of reservation entries; hmaster values 0..N_MASTERS-1 are valid.
- W_ADDR, 32, address width.
- W_DATA, 32, data width.
- GRANULE_LOG2, 3, reservation granule is 2^GRANULE_LOG2 bytes; compare haddr[W_ADDR-1:GRANULE_LOG2].

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- src_hready  in  1  bus HREADY from crossbar
- src_hready_resp  out  1  HREADYOUT to crossbar
- src_hresp  out  1  HRESP to crossbar
- src_haddr  in  W_ADDR
- src_hwrite  in  1
- src_htrans  in  2
- src_hsize  in  3
- src_hburst  in  3
- src_hprot  in  4
- src_hmastlock  in  1
- src_hwdata  in  W_DATA
- src_hrdata  out  W_DATA
- src_hexcl  in  1  exclusive transfer flag (address phase)
- src_hmaster  in  8  master ID (address phase)
- src_hexokay  out  1  exclusive success (data phase)
- dst_hready  out  1  equals src_hready
- dst_hready_resp  in  1
- dst_hresp  in  1
- dst_haddr, dst_hwrite, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata  out  same widths as src_ counterparts  pass-through
- dst_htrans  out  2  src_htrans, forced IDLE for a failing exclusive write
- dst_hrdata  in  W_DATA

Behaviour:
- Transfer acceptance:
  - Address phase accepted when src_hready=1 and src_htrans[1]=1.
  - Accepted attributes are registered into the data-phase state: valid, write, excl, midx, granule, suppressed.
- Reservation table: per master, a valid bit plus a granule tag. Reset clears all valid bits and the data-phase state.
- Reset values: src_hready_resp=1, src_hresp=0, src_hexokay=0.
- Master index: midx = src_hmaster when src_hmaster < N_MASTERS; otherwise the master is "unknown". An exclusive from an unknown master always fails and never reserves.
- Exclusive write check, in the address phase:
  - Pass = entry[midx] valid AND tag == addr granule.
  - The check uses the table as it will be after the completing data phase's update in this same cycle (forwarding). A back-to-back store immediately behind a clearing write therefore sees the cleared state.
- Failed exclusive write:
  - dst_htrans = IDLE for that address phase.
  - Data phase is owned by the monitor: src_hready_resp=1, src_hresp=0, src_hexokay=0, src_hrdata=0. Exactly 1 cycle.
- All other data phases: src_hready_resp, src_hresp and src_hrdata come from dst_*.
- src_hexokay = 1 only in the final data-phase cycle (hready_resp=1, hresp=0) of:
  - a passing exclusive write, or
  - an exclusive read that sets a reservation.
  Otherwise src_hexokay is 0.
- Table updates are applied at data-phase completion (src_hready_resp=1) and only when hresp=0:
  - Exclusive read: entry[midx] = {1, granule}; this replaces any prior reservation.
  - Any performed write (normal or passing exclusive) to granule G clears every entry whose tag == G, including the writer's own.
  - A passing exclusive write additionally clears entry[midx].
  - Suppressed writes and normal reads change nothing.
- On an error response (hresp=1, both cycles): no reservation is set and no clear is applied; src_hexokay=0.
- Simultaneous events: the completing data-phase update and the new address-phase check occur in the same cycle; the order is update first, then check.
- Reset mid-transfer: the data phase is abandoned, the table is cleared and outputs return to reset values on the next edge.

Decomposition:
- Shared package ahbl_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - function for granule extraction
  - function for master-index validity
- One sub-module, ahbl_excl_resv_table:
  - N_MASTERS entries
  - set port (idx, tag)
  - clear-by-tag port
  - combinational lookup with forwarding of the same-cycle set/clear

Test Plan:
- Master 0 exclusive read 0x100 then exclusive write 0x100 -> slave sees the write (htrans=NONSEQ), hexokay=1 on both data phases.
- Master 0 exclusive read 0x100; master 1 normal write 0x104; master 0 exclusive write 0x100 -> third transfer: dst_htrans=IDLE, src_hexokay=0, src_hready_resp=1, memory unchanged.
- Masters 0 and 1 both exclusive read 0x200; master 1 exclusive write 0x200 passes -> master 0's following exclusive write 0x200 fails with hexokay=0.
- Exclusive write with no prior reservation, hmaster=5 (N_MASTERS=2) -> suppressed, hexokay=0; an exclusive read with hmaster=5 returns data with hexokay=0 and sets nothing.
- Exclusive read completing with slave ERROR (2-cycle hresp=1) -> no reservation; the following exclusive write to the same address fails.
- Slave wait states (dst_hready_resp low 3 cycles) on an exclusive read, then rst=1 for one cycle mid-phase -> all outputs at reset values; a subsequent exclusive write fails.
